// File: rtl/addrdecode_tracked.sv
// addrdecode_tracked: registered address decoder with outstanding-transaction
// tracking. Requests to a different slave are held until every earlier
// transaction has been acknowledged, so responses return in order.
// Optional build macro ADDRDECODE_LOWPOWER_EN: when defined, o_addr, o_data
// and o_decode are zeroed whenever o_valid is low.
module addrdecode_tracked #(
   parameter int unsigned NS         = 8,
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 38,
   parameter logic [NS*AW-1:0] SLAVE_ADDR = {
      32'hE000_0000, 32'hC000_0000, 32'hA000_0000, 32'h8000_0000,
      32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
   parameter logic [NS*AW-1:0] SLAVE_MASK = {
      32'hE000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000,
      32'hE000_0000, 32'hE000_0000, 32'hF000_0000, 32'hF000_0000},
   parameter int unsigned LGMAXBURST = 6
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_valid,
   output logic                  o_stall,
   input  logic [AW-1:0]         i_addr,
   input  logic [DW-1:0]         i_data,
   output logic                  o_valid,
   input  logic                  i_stall,
   output logic [NS:0]           o_decode,
   output logic [AW-1:0]         o_addr,
   output logic [DW-1:0]         o_data,
   input  logic                  i_ack,
   input  logic                  i_abort,
   output logic [LGMAXBURST:0]   o_outstanding,
   output logic                  o_busy
);

   localparam int unsigned DECW = NS + 1;
   localparam int unsigned CW   = LGMAXBURST + 1;
   localparam logic [CW-1:0] MAX_CNT = {1'b1, {LGMAXBURST{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOCKED,
      ST_DRAIN
   } state_t;

   state_t           state_c;
   logic [DECW-1:0]  dec_c;
   logic [DECW-1:0]  req_c;
   logic             hit_c;
   logic             stall_c;
   logic             accept_c;
   logic             issue_c;
   logic             ack_c;
   logic             drained_c;

   logic             valid_q, valid_d;
   logic [DECW-1:0]  dec_q, dec_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DECW-1:0]  lock_q, lock_d;
   logic             busy_q, busy_d;

   // Address decode: lowest matching slave wins, error slot when none match
   always_comb begin
      dec_c = '0;
      hit_c = 1'b0;
      for (int unsigned k = 0; k < NS; k++) begin
         if (!hit_c && ((i_addr ^ SLAVE_ADDR[k*AW +: AW]) & SLAVE_MASK[k*AW +: AW]) == '0) begin
            dec_c[k] = 1'b1;
            hit_c    = 1'b1;
         end
      end
      if (!hit_c) begin
         dec_c[NS] = 1'b1;
      end
      req_c = i_valid ? dec_c : '0;
   end

   // Classify the lock relative to the incoming request
   always_comb begin
      state_c = ST_LOCKED;
      if (lock_q == '0) begin
         state_c = ST_IDLE;
      end else if (i_valid && (req_c != lock_q)) begin
         state_c = ST_DRAIN;
      end
   end

   // Next-state logic for the output stage, counter and lock
   always_comb begin
      valid_d = valid_q;
      dec_d   = dec_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      lock_d  = lock_q;

      stall_c   = (valid_q && i_stall) || (state_c == ST_DRAIN) ||
                  (cnt_q == MAX_CNT) || i_abort;
      accept_c  = i_valid && !stall_c;
      issue_c   = valid_q && !i_stall;
      ack_c     = i_ack && (cnt_q != '0);
      drained_c = (cnt_q == '0) && !valid_q;

      // Saturating up/down count of issued-but-unacknowledged transactions
      if (issue_c && !ack_c) begin
         if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (ack_c && !issue_c) begin
         cnt_d = cnt_q - CW'(1);
      end

      if (accept_c) begin
         valid_d = 1'b1;
         dec_d   = req_c;
         addr_d  = i_addr;
         data_d  = i_data;
         lock_d  = req_c;
      end else begin
         if (issue_c) begin
            valid_d = 1'b0;
            dec_d   = '0;
`ifdef ADDRDECODE_LOWPOWER_EN
            addr_d  = '0;
            data_d  = '0;
`endif
         end
         // Release the lock once fully drained and nothing matching is waiting
         if ((state_c != ST_IDLE) && drained_c && ((state_c == ST_DRAIN) || !i_valid)) begin
            lock_d = '0;
         end
      end

      if (i_abort) begin
         valid_d = 1'b0;
         dec_d   = '0;
         cnt_d   = '0;
         lock_d  = '0;
`ifdef ADDRDECODE_LOWPOWER_EN
         addr_d  = '0;
         data_d  = '0;
`endif
      end

      busy_d = valid_d || (cnt_d != '0);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         valid_q <= 1'b0;
         dec_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         lock_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         dec_q   <= dec_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         busy_q  <= busy_d;
      end
   end

   assign o_stall       = stall_c;
   assign o_valid       = valid_q;
   assign o_decode      = dec_q;
   assign o_addr        = addr_q;
   assign o_data        = data_q;
   assign o_outstanding = cnt_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_addrdecode_tracked.sv
// tb_addrdecode_tracked: directed scenarios plus randomized traffic checked
// against a behavioural model; payloads go through a scoreboard queue.
module tb_addrdecode_tracked;

   localparam int unsigned NS   = 8;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 38;
   localparam int unsigned LG   = 2;
   localparam int unsigned DECW = NS + 1;
   localparam int          MAXC = 1 << LG;

   logic            clk = 1'b0;
   logic            i_reset_n, i_valid, i_stall, i_ack, i_abort;
   logic [AW-1:0]   i_addr;
   logic [DW-1:0]   i_data;
   logic            o_stall, o_valid, o_busy;
   logic [NS:0]     o_decode;
   logic [AW-1:0]   o_addr;
   logic [DW-1:0]   o_data;
   logic [LG:0]     o_outstanding;

   typedef struct packed {
      logic [DECW-1:0] dec;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
   } txn_t;

   txn_t sbq[$];
   txn_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   m_cnt;
   bit   m_valid;
   int   m_lock;
   bit   mon_en = 1'b0;
   bit   obs_stall;

   addrdecode_tracked #(.LGMAXBURST(LG)) dut (
      .i_clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_stall(o_stall),
      .i_addr(i_addr), .i_data(i_data), .o_valid(o_valid), .i_stall(i_stall),
      .o_decode(o_decode), .o_addr(o_addr), .o_data(o_data), .i_ack(i_ack),
      .i_abort(i_abort), .o_outstanding(o_outstanding), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   // Reference address map by top nibble
   function automatic int slave_of(input logic [AW-1:0] a);
      int n;
      n = int'(a[31:28]);
      if (n == 0) return 0;
      if (n == 2) return 1;
      if (n >= 4) return n / 2;
      return NS;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      return DW'({$urandom, $urandom});
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive, predict, check at negedge, advance model
   task automatic cycle(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit st, input bit ak, input bit ab);
      int   slv;
      bit   m_stall, acc, iss, ackv, drained;
      txn_t t;
      i_valid = v; i_addr = a; i_data = d; i_stall = st; i_ack = ak; i_abort = ab;
      slv     = slave_of(a);
      m_stall = ab || (m_valid && st) || (m_cnt == MAXC) || (v && m_lock >= 0 && slv != m_lock);
      acc     = v && !m_stall;
      if (acc) begin
         t.dec  = DECW'(1) << slv;
         t.addr = a;
         t.data = d;
         sbq.push_back(t);
      end
      @(negedge clk);
      obs_stall = o_stall;
      chk("stall", 64'(o_stall), 64'(m_stall));
      chk("valid", 64'(o_valid), 64'(m_valid));
      chk("outstanding", 64'(o_outstanding), 64'(m_cnt));
      chk("busy", 64'(o_busy), 64'(m_valid || m_cnt != 0));
      @(posedge clk);
      iss     = m_valid && !st;
      ackv    = ak && m_cnt > 0;
      drained = (m_cnt == 0) && !m_valid;
      if (ab) begin
         m_valid = 1'b0;
         m_cnt   = 0;
         m_lock  = -1;
         sbq.delete();
      end else begin
         if (iss && !ackv) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
         else if (ackv && !iss) m_cnt = m_cnt - 1;
         if (acc) m_lock = slv;
         else if (m_lock >= 0 && drained && (!v || slv != m_lock)) m_lock = -1;
         m_valid = acc ? 1'b1 : (iss ? 1'b0 : m_valid);
      end
      #1;
   endtask

   task automatic idle(input bit ak);
      cycle(1'b0, '0, '0, 1'b0, ak, 1'b0);
   endtask

   task automatic do_reset(input int n);
      i_reset_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_ack = 1'b0; i_abort = 1'b0;
      i_addr = '0; i_data = '0;
      repeat (n) @(posedge clk);
      m_cnt = 0; m_valid = 1'b0; m_lock = -1;
      sbq.delete();
      #1;
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_decode", 64'(o_decode), 64'(0));
      chk("rst_addr", 64'(o_addr), 64'(0));
      chk("rst_data", 64'(o_data), 64'(0));
      chk("rst_outstanding", 64'(o_outstanding), 64'(0));
      chk("rst_busy", 64'(o_busy), 64'(0));
      chk("rst_stall", 64'(o_stall), 64'(0));
      i_reset_n = 1'b1;
   endtask

   // Scoreboard monitor: presented output must match the oldest accepted request
   always @(negedge clk) begin
      if (mon_en && i_reset_n) begin
         if (o_valid === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("FAIL sb_empty: o_valid=1 with no expected request, dec=0x%0h", o_decode);
            end else begin
               mon_e = sbq[0];
               if (o_decode !== mon_e.dec || o_addr !== mon_e.addr || o_data !== mon_e.data) begin
                  bad++;
                  $display("FAIL sb_payload: got dec=0x%0h addr=0x%0h data=0x%0h expected dec=0x%0h addr=0x%0h data=0x%0h",
                           o_decode, o_addr, o_data, mon_e.dec, mon_e.addr, mon_e.data);
               end
               if (!i_stall) void'(sbq.pop_front());
            end
         end
         total++;
         if ((o_valid !== (o_decode != '0)) || !$onehot0(o_decode)) begin
            bad++;
            $display("FAIL invariant: o_valid=%b o_decode=0x%0h expected one-hot decode iff valid", o_valid, o_decode);
         end
      end
   end

   initial begin
      logic [3:0] nib;
      bit         v, st, ak, ab;
      i_reset_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_ack = 1'b0; i_abort = 1'b0;
      i_addr = '0; i_data = '0;
      m_cnt = 0; m_valid = 1'b0; m_lock = -1;
      do_reset(2);
      mon_en = 1'b1;

      // Same-slave burst
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 32'h2000_0000 + 32'(4 * i), rnd_data(), 1'b0, 1'b0, 1'b0);
         if (i == 0) chk("burst_decode", 64'(o_decode), 64'h002);
      end
      idle(1'b0);
      chk("burst_count", 64'(o_outstanding), 64'(4));
      repeat (4) idle(1'b1);
      chk("burst_drain", 64'(o_outstanding), 64'(0));
      idle(1'b0);

      // Slave switch waits for drain plus one cycle
      cycle(1'b1, 32'h0000_0010, rnd_data(), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h4000_0000, 38'h11, 1'b0, 1'b0, 1'b0);
      chk("switch_stall", 64'(obs_stall), 64'(1));
      cycle(1'b1, 32'h4000_0000, 38'h11, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h4000_0000, 38'h11, 1'b0, 1'b0, 1'b0);
      chk("switch_drain_stall", 64'(obs_stall), 64'(1));
      cycle(1'b1, 32'h4000_0000, 38'h11, 1'b0, 1'b0, 1'b0);
      chk("switch_decode", 64'(o_decode), 64'h004);
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);

      // Unmapped address goes to the error slot
      cycle(1'b1, 32'h1000_0000, rnd_data(), 1'b0, 1'b0, 1'b0);
      chk("unmapped_decode", 64'(o_decode), 64'h100);
      idle(1'b0);
      chk("unmapped_count", 64'(o_outstanding), 64'(1));
      idle(1'b1);
      chk("unmapped_ack", 64'(o_outstanding), 64'(0));
      idle(1'b0);

      // Saturation and simultaneous issue/ack
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h6000_0000 + 32'(i), rnd_data(), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h6000_0100, rnd_data(), 1'b1, 1'b0, 1'b0);
      chk("sat_stall", 64'(obs_stall), 64'(1));
      chk("sat_count", 64'(o_outstanding), 64'(4));
      idle(1'b1);
      chk("sat_simul", 64'(o_outstanding), 64'(4));
      idle(1'b1);
      chk("sat_ack", 64'(o_outstanding), 64'(3));
      repeat (3) idle(1'b1);
      idle(1'b0);

      // Backpressure hold
      cycle(1'b1, 32'hA000_0040, 38'h2A_5A5A_5A5A, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'hA000_0080, rnd_data(), 1'b1, 1'b0, 1'b0);
         chk("hold_stall", 64'(obs_stall), 64'(1));
         chk("hold_addr", 64'(o_addr), 64'h0000_0000_A000_0040);
         chk("hold_decode", 64'(o_decode), 64'h020);
      end
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);

      // Abort with traffic in flight
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC000_0000 + 32'(i), rnd_data(), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hC000_0010, rnd_data(), 1'b1, 1'b0, 1'b1);
      chk("abort_stall", 64'(obs_stall), 64'(1));
      chk("abort_valid", 64'(o_valid), 64'(0));
      chk("abort_count", 64'(o_outstanding), 64'(0));
      idle(1'b1);
      chk("abort_late_ack", 64'(o_outstanding), 64'(0));

      // Reset mid-operation
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hE000_0000 + 32'(i), rnd_data(), 1'b0, 1'b0, 1'b0);
      do_reset(1);
      idle(1'b1);
      chk("reset_late_ack", 64'(o_outstanding), 64'(0));

      // Randomized traffic
      nib = 4'h2;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset(1);
         end else begin
            if ($urandom_range(0, 3) == 0) nib = 4'($urandom_range(0, 15));
            v  = $urandom_range(0, 9) < 7;
            st = $urandom_range(0, 9) < 3;
            ak = (m_cnt > 0) && ($urandom_range(0, 9) < 4);
            ab = $urandom_range(0, 99) == 0;
            cycle(v, {nib, 28'($urandom)}, rnd_data(), st, ak, ab);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addrdecode_tracked.md
# addrdecode_tracked

Registered Wishbone-style address decoder that steers each request to one of NS slaves, or to an error slot for unmapped addresses, and tracks outstanding transactions. It holds requests to a different slave until every earlier transaction has been acknowledged, which preserves return ordering. It sits between a master-side request stream and the crossbar/slave mux, one instance per master.

## Interface

Parameters:
- NS, 8, number of slaves; decode vector is NS+1 bits, bit NS = no slave matched.
- AW, 32, address width.
- DW, 38, payload width carried alongside the address.
- SLAVE_ADDR, NS*AW bits, per-slave base. Default slave 0 = 0x0, slave 1 = 0x2000_0000, slaves 2..7 = 0x4000_0000..0xE000_0000 in 0x2000_0000 steps.
- SLAVE_MASK, NS*AW bits, per-slave compare mask. Default 0xF000_0000 for slaves 0–1 and 0xE000_0000 for slaves 2–7.
- LGMAXBURST, 6, log2 of the maximum number of outstanding transactions.

Ports:
- i_clk  in  1  system clock; one clock domain.
- i_reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  request present.
- o_stall  out  1  request not accepted this cycle.
- i_addr  in  AW  request address.
- i_data  in  DW  request payload.
- o_valid  out  1  registered request to slave side.
- i_stall  in  1  slave side cannot accept.
- o_decode  out  NS+1  one-hot slave select, registered.
- o_addr  out  AW  registered address.
- o_data  out  DW  registered payload.
- i_ack  in  1  one pulse per completed transaction, from any slave or the error responder.
- i_abort  in  1  bus cycle dropped; discard all tracking.
- o_outstanding  out  LGMAXBURST+1  issued-but-unacknowledged count.
- o_busy  out  1  o_valid or o_outstanding != 0.

## Operation

- **Decode (combinational).** Slave k matches when ((i_addr ^ SLAVE_ADDR[k]) & SLAVE_MASK[k]) == 0.
  - If several slaves match, the lowest index wins, so the request vector is always one-hot.
  - If none match, bit NS is set.
  - With !i_valid, the request vector is 0.
- **Lock register.** A lock register of NS+1 bits holds the decode of the last issued request. It is 0 when idle.
- **States:**
  - IDLE: lock == 0.
  - LOCKED: lock != 0 and the incoming decode equals lock, or there is no request.
  - DRAIN: i_valid and the decode differs from a nonzero lock.
- **Transitions:**
  - IDLE→LOCKED on accept.
  - LOCKED→DRAIN when a mismatching request arrives.
  - DRAIN→IDLE when o_outstanding == 0 and !o_valid; lock clears that cycle, and the request is accepted the following cycle.
  - LOCKED→IDLE under the same drain condition with no request pending.
- **Stall.** o_stall = (o_valid && i_stall) || (state == DRAIN) || (o_outstanding == 2^LGMAXBURST). A request is accepted when i_valid && !o_stall.
- **Acceptance.** On accept, the output registers load the address, payload and decode, o_valid <= 1, and lock <= decode.
- **Output release.** If o_valid && !i_stall and no accept occurs, o_valid <= 0.
- **Counter.**
  - +1 on (o_valid && !i_stall); −1 on i_ack.
  - Both in the same cycle: count unchanged.
  - i_ack at count 0 is ignored; the count stays 0.
  - The count never exceeds 2^LGMAXBURST.
- **Error slot.** Unmapped requests (bit NS) are issued and counted like any slave; the downstream error responder supplies the i_ack.
- **Abort.** i_abort (while reset is inactive) clears o_valid, o_decode, the counter and the lock on the next edge. A request presented in the abort cycle is not accepted (o_stall = 1).

## Timing

- **Reset values:** o_valid = 0, o_decode = 0, o_addr = 0, o_data = 0, o_outstanding = 0, o_busy = 0, lock = 0.
  - o_stall is combinational: with all registers cleared it reads 0 unless i_abort is asserted.
- **Latency:** 1 cycle from accept to o_valid. With i_stall low, the block sustains one request per cycle to the same slave.
- **Stability:** while o_valid && i_stall, o_addr, o_data and o_decode are held stable.
- **Switch cost:** switching slaves costs drain time plus 1 idle cycle.
- **Invariants:**
  - o_valid == (o_decode != 0).
  - o_decode is one-hot or zero.
- **Reset mid-operation** discards all pending and outstanding state; late acks after reset are ignored at count 0.

## Configuration

- **ADDRDECODE_LOWPOWER_EN** defined: o_addr, o_data and o_decode are forced to 0 whenever o_valid is 0, both after release and after abort.
- **ADDRDECODE_LOWPOWER_EN** undefined: o_addr and o_data retain their last values after release, while o_decode still clears so the validity invariant holds.

## Test plan

- **Same-slave burst.** Reset low for 2 cycles, then 4 back-to-back requests at 0x2000_0000..0x2000_000C with i_stall = 0 → o_decode = 0x002 for 4 cycles starting 1 cycle after the first accept, o_outstanding reaches 4, and 4 i_ack pulses return it to 0.
- **Slave switch.** Issue at 0x0000_0010 (ack not yet returned), then present 0x4000_0000 → o_stall high. After i_ack, o_outstanding = 0 and lock clears; the request is accepted on the next cycle and o_decode = 0x004.
- **Unmapped address.** Request at 0x1000_0000 → o_decode = 0x100 (bit NS) and the counter increments; i_ack decrements it.
- **Saturation and simultaneity.** With LGMAXBURST = 2, issue 4 requests without acks → o_stall held high at count 4. Then i_ack together with a new issue → count stays 4. Then i_ack alone → count 3.
- **Backpressure hold.** Hold i_stall = 1 for 5 cycles with o_valid = 1 → o_addr, o_data and o_decode are unchanged and o_stall = 1.
- **Abort and reset.** Assert i_abort with 3 outstanding and o_valid = 1 → next cycle o_valid = 0 and o_outstanding = 0; a subsequent i_ack leaves the count at 0. Repeat with i_reset_n = 0 → all outputs 0.
